// File: rtl/square_wave_sequencer_pkg.sv
// Shared types for the square-wave program sequencer.
// State encoding and table entry field widths.
package square_wave_sequencer_pkg;

    localparam int M_W = 4;
    localparam int N_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/square_wave_sequencer_seq_table.sv
// Program table: one synchronous write port, one combinational read port.
// The whole table is cleared while reset is low.
module seq_table
    import square_wave_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [IW-1:0]  wr_addr,
    input  logic [M_W-1:0] wr_m,
    input  logic [N_W-1:0] wr_n,
    input  logic [CW-1:0]  wr_cycles,
    input  logic [IW-1:0]  rd_addr,
    output logic [M_W-1:0] rd_m,
    output logic [N_W-1:0] rd_n,
    output logic [CW-1:0]  rd_cycles
);

    logic [M_W-1:0] m_mem [DEPTH];
    logic [N_W-1:0] n_mem [DEPTH];
    logic [CW-1:0]  c_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] <= '0;
                n_mem[i] <= '0;
                c_mem[i] <= '0;
            end
        end else if (wr_en) begin
            m_mem[wr_addr] <= wr_m;
            n_mem[wr_addr] <= wr_n;
            c_mem[wr_addr] <= wr_cycles;
        end
    end

    assign rd_m      = m_mem[rd_addr];
    assign rd_n      = n_mem[rd_addr];
    assign rd_cycles = c_mem[rd_addr];

endmodule

// File: rtl/square_wave_sequencer.sv
// Plays a table of (m, n, cycles) entries on one square_wave generator.
// All outputs are registered from the next-state decision.
module square_wave_sequencer
    import square_wave_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           loop,
    input  logic [IW-1:0]  last_idx,
    input  logic           wr_en,
    input  logic [IW-1:0]  wr_addr,
    input  logic [M_W-1:0] wr_m,
    input  logic [N_W-1:0] wr_n,
    input  logic [CW-1:0]  wr_cycles,
    input  logic           sq_out,
    output logic           sq_en,
    output logic           sq_clr,
    output logic [M_W-1:0] sq_m,
    output logic [N_W-1:0] sq_n,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  cur_idx
);

    state_t         state, state_nx;
    logic [IW-1:0]  idx_nx;
    logic [CW-1:0]  cycles_q;
    logic [CW-1:0]  period_cnt, period_cnt_nx;
    logic           sq_out_d;
    logic           rise;
    logic           skip;
    logic [M_W-1:0] rd_m;
    logic [N_W-1:0] rd_n;
    logic [CW-1:0]  rd_cycles;

    // Read address is the index being loaded, so LOAD sees pre-write data.
    seq_table #(.DEPTH(DEPTH), .CW(CW)) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_m      (wr_m),
        .wr_n      (wr_n),
        .wr_cycles (wr_cycles),
        .rd_addr   (idx_nx),
        .rd_m      (rd_m),
        .rd_n      (rd_n),
        .rd_cycles (rd_cycles)
    );

    assign rise = sq_out & ~sq_out_d;
    assign skip = (cycles_q == '0) || (sq_m == '0) || (sq_n == '0);

    always_comb begin
        state_nx      = state;
        idx_nx        = cur_idx;
        period_cnt_nx = period_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end
            end
            LOAD: state_nx = skip ? NEXT : RUN;
            RUN: begin
                if (rise) begin
                    if (period_cnt == cycles_q - CW'(1))
                        state_nx = NEXT;
                    else
                        period_cnt_nx = period_cnt + CW'(1);
                end
            end
            NEXT: begin
                if (cur_idx != last_idx) begin
                    idx_nx   = cur_idx + IW'(1);
                    state_nx = LOAD;
                end else if (loop) begin
                    idx_nx   = '0;
                    state_nx = LOAD;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur_idx    <= '0;
            sq_m       <= '0;
            sq_n       <= '0;
            cycles_q   <= '0;
            period_cnt <= '0;
            sq_out_d   <= 1'b0;
            sq_en      <= 1'b0;
            sq_clr     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            period_cnt <= period_cnt_nx;
            sq_out_d   <= (state == LOAD) ? 1'b0 : sq_out;
            sq_en      <= (state_nx == RUN);
            sq_clr     <= (state_nx != RUN);
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            if (state_nx == LOAD) begin
                cur_idx    <= idx_nx;
                sq_m       <= rd_m;
                sq_n       <= rd_n;
                cycles_q   <= rd_cycles;
                period_cnt <= '0;
                sq_out_d   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_wave_sequencer.sv
// Directed bench for square_wave_sequencer; sq_out rises are driven by hand.
// Each scenario task checks its own expected values inline.
module tb_square_wave_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop = 1'b0;
    logic [IW-1:0] last_idx = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [3:0]    wr_m = '0;
    logic [3:0]    wr_n = '0;
    logic [CW-1:0] wr_cycles = '0;
    logic          sq_out = 1'b0;
    logic          sq_en, sq_clr, busy, done;
    logic [3:0]    sq_m, sq_n;
    logic [IW-1:0] cur_idx;

    int n_chk = 0;
    int n_fail = 0;

    square_wave_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .loop      (loop),
        .last_idx  (last_idx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_m      (wr_m),
        .wr_n      (wr_n),
        .wr_cycles (wr_cycles),
        .sq_out    (sq_out),
        .sq_en     (sq_en),
        .sq_clr    (sq_clr),
        .sq_m      (sq_m),
        .sq_n      (sq_n),
        .busy      (busy),
        .done      (done),
        .cur_idx   (cur_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int m, input int n, input int c);
        wr_en = 1'b1;
        wr_addr = IW'(a);
        wr_m = 4'(m);
        wr_n = 4'(n);
        wr_cycles = CW'(c);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rise();
        sq_out = 1'b1;
        tick();
        sq_out = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_chk++; if (sq_clr !== 1'b1) begin n_fail++;
            $display("FAIL rst_sq_clr: got %b want 1", sq_clr); end
        n_chk++; if (sq_en !== 1'b0) begin n_fail++;
            $display("FAIL rst_sq_en: got %b want 0", sq_en); end
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL rst_done: got %b want 0", done); end
        n_chk++; if (cur_idx !== 2'd0) begin n_fail++;
            $display("FAIL rst_cur_idx: got %0d want 0", cur_idx); end
        reset = 1'b1;
        loop = 1'b0;
        last_idx = 2'd0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL idle_abort_busy: got %b want 0", busy); end
        go();
        n_chk++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL rst_load_busy: got %b want 1", busy); end
        n_chk++; if ({sq_m, sq_n} !== 8'h00) begin n_fail++;
            $display("FAIL rst_table_zero: got %h want 00", {sq_m, sq_n}); end
        tick();
        n_chk++; if (sq_en !== 1'b0) begin n_fail++;
            $display("FAIL rst_skip_en: got %b want 0", sq_en); end
        tick();
        n_chk++; if (done !== 1'b1) begin n_fail++;
            $display("FAIL rst_skip_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_single();
        wr(0, 1, 1, 3);
        last_idx = 2'd0;
        loop = 1'b0;
        go();
        n_chk++; if ({busy, sq_en, sq_clr} !== 3'b101) begin n_fail++;
            $display("FAIL single_load: got %b want 101", {busy, sq_en, sq_clr}); end
        tick();
        n_chk++; if ({sq_en, sq_clr} !== 2'b10) begin n_fail++;
            $display("FAIL single_run: got %b want 10", {sq_en, sq_clr}); end
        rise();
        tick();
        rise();
        n_chk++; if (sq_en !== 1'b1) begin n_fail++;
            $display("FAIL single_en_hold: got %b want 1", sq_en); end
        tick();
        rise();
        n_chk++; if ({sq_en, done, busy} !== 3'b001) begin n_fail++;
            $display("FAIL single_next: got %b want 001", {sq_en, done, busy}); end
        tick();
        n_chk++; if ({done, busy} !== 2'b11) begin n_fail++;
            $display("FAIL single_done: got %b want 11", {done, busy}); end
        tick();
        n_chk++; if ({done, busy} !== 2'b00) begin n_fail++;
            $display("FAIL single_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic test_skip();
        wr(0, 2, 1, 2);
        wr(1, 1, 1, 0);
        wr(2, 1, 3, 1);
        last_idx = 2'd2;
        loop = 1'b0;
        go();
        n_chk++; if ({cur_idx, sq_m, sq_n} !== {2'd0, 4'd2, 4'd1}) begin n_fail++;
            $display("FAIL skip_load0: got %0d/%0d/%0d want 0/2/1", cur_idx, sq_m, sq_n); end
        tick();
        rise();
        tick();
        rise();
        n_chk++; if (sq_en !== 1'b0) begin n_fail++;
            $display("FAIL skip_next0_en: got %b want 0", sq_en); end
        tick();
        n_chk++; if ({cur_idx, sq_en} !== {2'd1, 1'b0}) begin n_fail++;
            $display("FAIL skip_load1: got %0d/%b want 1/0", cur_idx, sq_en); end
        tick();
        n_chk++; if (sq_en !== 1'b0) begin n_fail++;
            $display("FAIL skip_next1_en: got %b want 0", sq_en); end
        tick();
        n_chk++; if ({cur_idx, sq_m, sq_n} !== {2'd2, 4'd1, 4'd3}) begin n_fail++;
            $display("FAIL skip_load2: got %0d/%0d/%0d want 2/1/3", cur_idx, sq_m, sq_n); end
        tick();
        n_chk++; if (sq_en !== 1'b1) begin n_fail++;
            $display("FAIL skip_run2_en: got %b want 1", sq_en); end
        rise();
        tick();
        n_chk++; if (done !== 1'b1) begin n_fail++;
            $display("FAIL skip_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_loop_abort();
        wr(0, 1, 1, 1);
        wr(1, 1, 1, 1);
        loop = 1'b1;
        last_idx = 2'd1;
        go();
        tick();
        rise();
        tick();
        n_chk++; if (cur_idx !== 2'd1) begin n_fail++;
            $display("FAIL loop_idx1: got %0d want 1", cur_idx); end
        tick();
        rise();
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL loop_next_done: got %b want 0", done); end
        tick();
        n_chk++; if ({cur_idx, done, busy} !== {2'd0, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL loop_wrap: got %0d/%b/%b want 0/0/1", cur_idx, done, busy); end
        tick();
        n_chk++; if (sq_en !== 1'b1) begin n_fail++;
            $display("FAIL loop_rerun_en: got %b want 1", sq_en); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if ({busy, sq_clr, sq_en, done} !== 4'b0100) begin n_fail++;
            $display("FAIL abort_idle: got %b want 0100", {busy, sq_clr, sq_en, done}); end
        tick();
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL abort_no_done: got %b want 0", done); end
    endtask

    task automatic test_write_during_play();
        wr(0, 1, 1, 2);
        loop = 1'b1;
        last_idx = 2'd0;
        go();
        tick();
        wr(0, 3, 3, 1);
        n_chk++; if ({sq_m, sq_en} !== {4'd1, 1'b1}) begin n_fail++;
            $display("FAIL wr_play_hold: got %0d/%b want 1/1", sq_m, sq_en); end
        rise();
        tick();
        rise();
        tick();
        n_chk++; if ({sq_m, sq_n, cur_idx} !== {4'd3, 4'd3, 2'd0}) begin n_fail++;
            $display("FAIL wr_play_new: got %0d/%0d/%0d want 3/3/0", sq_m, sq_n, cur_idx); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL wr_play_abort: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        loop = 1'b1;
        last_idx = 2'd1;
        go();
        tick();
        rise();
        tick();
        tick();
        n_chk++; if ({cur_idx, sq_en} !== {2'd1, 1'b1}) begin n_fail++;
            $display("FAIL b2b_run1: got %0d/%b want 1/1", cur_idx, sq_en); end
        go();
        n_chk++; if ({cur_idx, sq_en, busy} !== {2'd1, 1'b1, 1'b1}) begin n_fail++;
            $display("FAIL b2b_start_ignored: got %0d/%b/%b want 1/1/1", cur_idx, sq_en, busy); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_chk++; if ({busy, sq_en, sq_clr} !== 3'b001) begin n_fail++;
            $display("FAIL b2b_start_abort: got %b want 001", {busy, sq_en, sq_clr}); end
    endtask

    task automatic test_mid_reset();
        loop = 1'b0;
        last_idx = 2'd0;
        go();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_chk++; if ({busy, sq_en, sq_clr, sq_m} !== {3'b001, 4'd0}) begin n_fail++;
            $display("FAIL mid_rst_out: got %b/%0d want 001/0", {busy, sq_en, sq_clr}, sq_m); end
        go();
        n_chk++; if ({sq_m, sq_n} !== 8'h00) begin n_fail++;
            $display("FAIL mid_rst_table: got %h want 00", {sq_m, sq_n}); end
        tick();
        tick();
        n_chk++; if (done !== 1'b1) begin n_fail++;
            $display("FAIL mid_rst_done: got %b want 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_skip();
        test_loop_abort();
        test_write_during_play();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/square_wave_sequencer.md
Name: square_wave_sequencer

Overview:
Plays a short program of square-wave settings on one square_wave generator instance. The program is a table of (m, n, cycles) entries. Each entry drives the generator's on/off intervals for a fixed number of output periods, then the block advances to the next entry. It sits between control logic (buttons/switch FSM) and the generator, and owns the generator's enable, clear and m/n inputs.

Parameters:
DEPTH, 4, number of program table entries (power of 2, >= 2)
CW, 8, width of per-entry period count
IW, $clog2(DEPTH), table index width (derived, not overridable)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  single-cycle request to begin playback at entry 0
abort  in  1  single-cycle request to stop playback immediately
loop  in  1  1 = wrap from last_idx back to entry 0; sampled at each end of table
last_idx  in  IW  index of final entry played; sampled at each end of table
wr_en  in  1  table write strobe
wr_addr  in  IW  table write index
wr_m  in  4  on interval for entry
wr_n  in  4  off interval for entry
wr_cycles  in  CW  number of output periods for entry
sq_out  in  1  generator output
sq_en  out  1  generator enable
sq_clr  out  1  generator clear (active-high, drives generator reset)
sq_m  out  4  generator m
sq_n  out  4  generator n
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
cur_idx  out  IW  entry currently loaded/playing

Behaviour:
- All outputs are registered. On reset: state=IDLE, table cleared to zeros, sq_clr=1, all other outputs 0, edge-detect register 0.
- Table: a write with wr_en=1 updates the entry at the next clock edge, in any state. The running entry's latched m/n/cycles are unaffected by the write. A write becomes visible at the next LOAD of that index. If a write and a LOAD of the same index occur in the same cycle, LOAD takes the old contents.
- IDLE: sq_en=0, sq_clr=1. start=1 -> LOAD with idx=0. start is ignored in every other state.
- LOAD (1 cycle): sq_clr=1, sq_en=0. Latch sq_m, sq_n and cycles from table[idx]; cur_idx=idx; period_cnt=0; clear the edge register. If cycles==0 or m==0 or n==0, the entry is skipped: go to NEXT. Otherwise go to RUN.
- RUN: sq_clr=0, sq_en=1. rise = sq_out & ~sq_out_d, where sq_out_d is sq_out registered. Each rise increments period_cnt. A rise with period_cnt==cycles-1 -> NEXT; sq_en is 0 from that NEXT cycle onward.
- NEXT (1 cycle): sq_en=0. If idx != last_idx: idx+1, go to LOAD. If idx == last_idx and loop=1: idx=0, go to LOAD. Otherwise go to DONE.
- last_idx >= DEPTH cannot occur (IW-wide); idx wraps naturally when last_idx=DEPTH-1.
- DONE (1 cycle): done=1, then IDLE.
- abort=1 in any non-IDLE state: next state IDLE, sq_en=0, sq_clr=1, done stays 0. abort wins over every other transition. abort in IDLE has no effect.
- Latency: start sampled at edge t -> busy=1 and LOAD at t+1 -> sq_en=1 at t+2.
- period_cnt is CW bits wide and never exceeds cycles-1, so no overflow is possible.
- Mid-operation reset: identical to power-on reset, including table clear.

Decomposition:
- Shared package holds: state encoding (IDLE, LOAD, RUN, NEXT, DONE) and the table entry field widths (M_W=4, N_W=4).
- One sub-module: seq_table (DEPTH x (4+4+CW) register file, one synchronous write port, one combinational read port, synchronous active-low clear).
- Edge detect and FSM stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 clocks -> sq_clr=1, sq_en=0, busy=0, done=0, cur_idx=0; a table read after release returns 0.
- Single entry: entry0=(m=1,n=1,cycles=3), last_idx=0, loop=0, start -> sq_en high until the 3rd rise of sq_out, done pulses exactly once, busy falls the cycle after done.
- Sequence with skip: entry0=(2,1,2), entry1=(1,1,0), entry2=(1,3,1), last_idx=2 -> sq_m/sq_n show 2/1 then 1/3, cur_idx goes 0,1,2, and entry1 produces no sq_en cycles.
- Loop and abort: loop=1, last_idx=1, entries 0/1 valid -> cur_idx wraps 1->0 with no done; abort during RUN -> next cycle IDLE, sq_clr=1, done=0.
- Write during play: rewrite entry0 to (3,3,1) while entry0 is running -> current sq_m unchanged; after wrap, LOAD shows sq_m=3.
- Start while busy and start+abort: start in RUN is ignored (cur_idx is not reset); start and abort in the same RUN cycle -> IDLE.
